alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Upstream feeder for the 4-bit signed ALU (ZNCV flags).
- Buffers operand/function commands in a small FIFO and presents one command at a time to the combinational ALU. After one settle cycle it captures the ALU result and flags into a result register with a valid/ready output.
- Supports chaining: the A operand can be replaced by the previous captured result, giving accumulator-style sequences.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- W, 4, operand/result width; fixed at 4 to match the ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH).
- cmd_a  in  W  operand A, signed.
- cmd_b  in  W  operand B, signed.
- cmd_func  in  4  ALU function code, passed through unmodified.
- cmd_chain  in  1  when 1, A is replaced by res_y at issue time.
- alu_a  out  W  ALU operand A (registered).
- alu_b  out  W  ALU operand B (registered).
- alu_func  out  4  ALU function (registered).
- alu_y  in  W  ALU result.
- alu_flags  in  4  ALU flags {Z,N,C,V}.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts result.
- res_y  out  W  captured result; holds its value after handoff.
- res_flags  out  4  captured {Z,N,C,V}.
- busy  out  1  1 when FSM not IDLE or FIFO non-empty.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO empty, count=0, FSM=IDLE, alu_a/alu_b/alu_func=0, res_valid=0, res_y=0, res_flags=0, busy=0. cmd_ready=1 whenever count=0, including during reset.
- Push: cmd_valid&cmd_ready at a rising edge writes {a,b,func,chain} at the write pointer.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged.
- No pass-through when full: cmd_ready=0 regardless of a same-cycle pop.
- FSM states:
  - IDLE: if count>0, pop head into alu_a/alu_b/alu_func and go to ISSUE; else stay.
  - ISSUE: one cycle for ALU inputs to settle. At the edge ending ISSUE, capture res_y<=alu_y and res_flags<=alu_flags, set res_valid=1, go to HOLD.
  - HOLD: res_valid=1, and res_y/res_flags are stable. On res_valid&res_ready:
    - clear res_valid;
    - if count>0 (evaluated before any same-edge push), pop the next command and go to ISSUE;
    - else go to IDLE.
- Chain: on pop, if the entry's chain=1 then alu_a<=res_y (current register value, i.e. the last captured result, or 0 after reset); else alu_a<=entry a.
- Latency: a command pushed into an empty FIFO with FSM IDLE at edge t is popped at edge t+1 and captured at edge t+2. res_valid is high after t+2.
- Throughput: with res_ready tied high, one result every 2 cycles.
- alu_* outputs hold their last values in IDLE and HOLD.
- Arithmetic: none performed here. Results and flags are passed verbatim from the ALU; no sign extension.
- Reset mid-operation (any state): every item listed above returns to its reset value on the next evaluation, with no result emitted for in-flight commands.

Test Plan:
- Single add: push A=7, B=4, func=0000 into idle block. Required: res_valid rises 2 cycles after the push edge; res_y=4'b1011 (-5); res_flags Z=0, N=1, C=0, V=1.
- Sub to zero: A=3, B=3, func=0001. Required: res_y=0, Z=1, N=0, V=0; alu_func=0001 during ISSUE.
- Chain: push (add 2,3, chain=0), then (add x,1, chain=1) with res_ready=1. Required: the second issue shows alu_a=5; results are 5 then 6 in order.
- Backpressure/full: hold res_ready=0 and offer 6 commands back-to-back. Required: 5 are accepted (1 in HOLD, 4 in FIFO); cmd_ready=0 with fifo_count=4 at the 6th. Releasing res_ready drains in order, one result per 2 cycles.
- Simultaneous push/pop: with count=2, push on the same edge as a HOLD handshake. Required: fifo_count stays 2 and order is preserved.
- Reset mid-HOLD: assert rst while res_valid=1 and count=3. Required: immediately res_valid=0, fifo_count=0, res_y=0, alu_a/alu_b/alu_func=0; after release the next push yields a correct fresh result.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Bundle of command, ALU and result signals that connect the issue stage
// to its producer, to the combinational 4-bit ALU and to the result consumer.
// The slave modport is the issue stage's view; master is the surroundings.
interface alu_issue_stage_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [3:0]    cmd_func;
    logic          cmd_chain;

    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_func;
    logic [W-1:0]  alu_y;
    logic [3:0]    alu_flags;

    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_y;
    logic [3:0]    res_flags;

    logic          busy;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_func, cmd_chain,
        input  alu_y, alu_flags, res_ready,
        output cmd_ready, alu_a, alu_b, alu_func,
        output res_valid, res_y, res_flags, busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_func, cmd_chain,
        output alu_y, alu_flags, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_func,
        input  res_valid, res_y, res_flags, busy, fifo_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 4-bit signed ALU. Commands are queued in a
// small FIFO, issued one at a time to the ALU, given one cycle to settle,
// and the ALU result/flags are then held in a result register until the
// consumer takes them. A chained command uses the last captured result
// as its A operand, which gives accumulator-style sequences.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input logic              clk,
    input logic              rst,
    alu_issue_stage_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   mem_a     [DEPTH];
    logic [W-1:0]   mem_b     [DEPTH];
    logic [3:0]     mem_func  [DEPTH];
    logic           mem_chain [DEPTH];

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           push;
    logic           pop;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_func;
    logic [W-1:0]   res_y;
    logic [3:0]     res_flags;

    // A full FIFO never accepts, even if the head is leaving this cycle;
    // count is async-reset so this reads 1 throughout reset.
    assign bus.cmd_ready  = (count < CW'(DEPTH));
    assign push           = bus.cmd_valid && bus.cmd_ready;

    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_func   = alu_func;
    assign bus.res_y      = res_y;
    assign bus.res_flags  = res_flags;
    assign bus.res_valid  = (state == HOLD);
    assign bus.busy       = (state != IDLE) || (count != '0);
    assign bus.fifo_count = count;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pop decision; count here is the pre-edge occupancy so a
    // push landing on the same edge can never be popped immediately.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]     <= bus.cmd_a;
            mem_b[wr_ptr]     <= bus.cmd_b;
            mem_func[wr_ptr]  <= bus.cmd_func;
            mem_chain[wr_ptr] <= bus.cmd_chain;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^PW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue registers feeding the ALU; a chained entry takes A from the
    // result register as it stands before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
        end else if (pop) begin
            alu_a    <= mem_chain[rd_ptr] ? res_y : mem_a[rd_ptr];
            alu_b    <= mem_b[rd_ptr];
            alu_func <= mem_func[rd_ptr];
        end
    end

    // Result register, loaded at the end of the settle cycle and then held
    // unchanged through HOLD and beyond the handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_y     <= '0;
            res_flags <= '0;
        end else if (state == ISSUE) begin
            res_y     <= bus.alu_y;
            res_flags <= bus.alu_flags;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed commands push their
// hand-computed result/flags into a queue, and an independent monitor pops
// and compares on every result handshake. A small ALU model closes the loop.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst;

    alu_issue_stage_if #(.W(4), .DEPTH(4)) bus ();

    alu_issue_stage #(.DEPTH(4), .W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_hs = -1;
    bit         rate_check = 1'b0;
    logic [7:0] sb [$];

    // Cycle counter used to measure result spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU model: func 0 add, func 1 subtract, else AND.
    always_comb begin
        logic [4:0] s;
        logic [3:0] y;
        logic       c;
        logic       v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (bus.alu_func)
            4'd0: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                y = s[3:0];
                c = s[4];
                v = (bus.alu_a[3] == bus.alu_b[3]) && (y[3] != bus.alu_a[3]);
            end
            4'd1: begin
                s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
                y = s[3:0];
                c = s[4];
                v = (bus.alu_a[3] != bus.alu_b[3]) && (y[3] != bus.alu_a[3]);
            end
            default: y = bus.alu_a & bus.alu_b;
        endcase
        bus.alu_y     = y;
        bus.alu_flags = {(y == 4'd0), y[3], c, v};
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one command; once accepted, its expected {y,flags} enters the scoreboard.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] func,
                                 input logic chain, input logic [7:0] exp);
        bit accepted = 1'b0;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_func  = func;
        bus.cmd_chain = chain;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (accepted) begin
            sb.push_back(exp);
        end else begin
            total++;
            bad++;
            $display("[TB] FAIL push_timeout: cmd_ready stayed 0 for a=%0h b=%0h", a, b);
        end
    endtask

    // Wait until everything issued has been checked and the block is idle.
    task automatic waitDrain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !bus.busy && !bus.res_valid;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: sb=%0d busy=%0b required sb=0 busy=0", sb.size(), bus.busy);
        end
        checkOutput("drain_sb_empty", 8'(sb.size()), 8'd0);
    endtask

    // Monitor: every result handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result: got %0h with empty scoreboard",
                         {bus.res_y, bus.res_flags});
            end else begin
                checkOutput("result", {bus.res_y, bus.res_flags}, sb.pop_front());
            end
            if (rate_check && last_hs >= 0) begin
                checkOutput("result_spacing", 8'(cyc - last_hs), 8'd2);
            end
            last_hs = cyc;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_func  = '0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b0;

        #1;
        checkOutput("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        checkOutput("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
        checkOutput("rst_count", {5'd0, bus.fifo_count}, 8'd0);
        checkOutput("rst_busy", {7'd0, bus.busy}, 8'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add 7+4 = -5 with overflow; two-cycle latency.
        $display("[TB] single add");
        applyStimulus(4'd7, 4'd4, 4'd0, 1'b0, 8'hB5);
        @(negedge clk);
        checkOutput("lat_edge0_valid", {7'd0, bus.res_valid}, 8'd0);
        @(negedge clk);
        checkOutput("lat_edge1_valid", {7'd0, bus.res_valid}, 8'd0);
        checkOutput("issue_alu_a", {4'd0, bus.alu_a}, 8'd7);
        checkOutput("issue_alu_b", {4'd0, bus.alu_b}, 8'd4);
        @(negedge clk);
        checkOutput("lat_edge2_valid", {7'd0, bus.res_valid}, 8'd1);
        bus.res_ready = 1'b1;
        waitDrain(20);

        // Subtract to zero.
        $display("[TB] sub to zero");
        @(posedge clk);
        #1;
        applyStimulus(4'd3, 4'd3, 4'd1, 1'b0, 8'h0A);
        @(negedge clk);
        @(negedge clk);
        checkOutput("issue_alu_func", {4'd0, bus.alu_func}, 8'd1);
        waitDrain(20);

        // Chain: 2+3, then result+1 with the A field ignored.
        $display("[TB] chain");
        @(posedge clk);
        #1;
        applyStimulus(4'd2, 4'd3, 4'd0, 1'b0, 8'h50);
        applyStimulus(4'hF, 4'd1, 4'd0, 1'b1, 8'h60);
        repeat (3) @(negedge clk);
        checkOutput("chain_alu_a", {4'd0, bus.alu_a}, 8'd5);
        waitDrain(20);

        // Backpressure: five accepted, sixth refused at count 4.
        $display("[TB] backpressure");
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(4'd1, 4'd1, 4'd0, 1'b0, 8'h20);
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b0, 8'h30);
        applyStimulus(4'd4, 4'd4, 4'd0, 1'b0, 8'h85);
        applyStimulus(4'd0, 4'd1, 4'd1, 1'b0, 8'hF4);
        applyStimulus(4'd8, 4'd8, 4'd0, 1'b0, 8'h0B);
        bus.cmd_a     = 4'd1;
        bus.cmd_b     = 4'd1;
        bus.cmd_func  = 4'd0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput("full_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
        checkOutput("full_count", {5'd0, bus.fifo_count}, 8'd4);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        checkOutput("full_count_after", {5'd0, bus.fifo_count}, 8'd4);
        last_hs       = -1;
        rate_check    = 1'b1;
        bus.res_ready = 1'b1;
        waitDrain(60);
        rate_check    = 1'b0;

        // Push on the same edge as a HOLD handshake with two queued.
        $display("[TB] simultaneous push/pop");
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(4'd1, 4'd2, 4'd0, 1'b0, 8'h30);
        applyStimulus(4'd2, 4'd2, 4'd0, 1'b0, 8'h40);
        applyStimulus(4'd3, 4'd3, 4'd0, 1'b0, 8'h60);
        checkOutput("simul_count_before", {5'd0, bus.fifo_count}, 8'd2);
        bus.res_ready = 1'b1;
        applyStimulus(4'd7, 4'd1, 4'd0, 1'b0, 8'h85);
        checkOutput("simul_count_after", {5'd0, bus.fifo_count}, 8'd2);
        waitDrain(40);

        // Reset while holding a result with three queued.
        $display("[TB] reset mid-hold");
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(4'd1, 4'd1, 4'd0, 1'b0, 8'h20);
        checkOutput("pre_rst_count", {5'd0, bus.fifo_count}, 8'd3);
        checkOutput("pre_rst_valid", {7'd0, bus.res_valid}, 8'd1);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("mid_rst_valid", {7'd0, bus.res_valid}, 8'd0);
        checkOutput("mid_rst_count", {5'd0, bus.fifo_count}, 8'd0);
        checkOutput("mid_rst_res_y", {4'd0, bus.res_y}, 8'd0);
        checkOutput("mid_rst_alu", {bus.alu_a, bus.alu_b}, 8'd0);
        checkOutput("mid_rst_func", {4'd0, bus.alu_func}, 8'd0);
        checkOutput("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        applyStimulus(4'd6, 4'hE, 4'd0, 1'b0, 8'h42);
        waitDrain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
